// File: rtl/gtp_pll_ctrl_pkg.sv
// Shared types and constants for the GTPE2_COMMON PLL sequencer.
package gtp_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PWRDN     = 3'd1,
    RESET     = 3'd2,
    WAIT_LOCK = 3'd3,
    LOCKED    = 3'd4,
    FAILED    = 3'd5
  } state_t;

  localparam logic [2:0] GTREFCLK0 = 3'd1;
  localparam logic [2:0] GTREFCLK1 = 3'd2;

  localparam int LOCK_FILTER_LEN = 32;

endpackage

// File: rtl/gtp_sync2.sv
// Two-flop synchronizer for a single asynchronous level; 2 cycles latency, no flow control.
module gtp_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gtp_pll_ctrl.sv
// GTPE2_COMMON PLL power-down/reset/lock sequencer with timeout and bounded retries.
// locked rises 3 cycles after pll_lock; optional lock filter via GTP_PLL_CTRL_LOCK_FILTER_EN.
module gtp_pll_ctrl
  import gtp_pll_ctrl_pkg::*;
#(
  parameter int PD_CYCLES    = 64,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] refclk_sel,
  input  logic       pll_lock,
  output logic       pll_pd,
  output logic       pll_reset,
  output logic [2:0] pll_refclk_sel,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  localparam logic [CNT_W-1:0] PD_LD  = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       MAX_R  = 4'(MAX_RETRIES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;
  logic             lock_ok;
  logic [3:0]       retry_inc;

  gtp_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

`ifdef GTP_PLL_CTRL_LOCK_FILTER_EN
  localparam int FW = $clog2(LOCK_FILTER_LEN);
  logic [FW-1:0] filt;

  // Counts consecutive high lock samples while waiting; any low sample restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
    end else if (state == WAIT_LOCK && lock_s && !start) begin
      filt <= filt + FW'(1);
    end else begin
      filt <= '0;
    end
  end

  assign lock_ok = lock_s && (filt == FW'(LOCK_FILTER_LEN - 1));
`else
  assign lock_ok = lock_s;
`endif

  assign retry_inc = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      pll_pd         <= 1'b1;
      pll_reset      <= 1'b1;
      pll_refclk_sel <= GTREFCLK0;
      busy           <= 1'b0;
      locked         <= 1'b0;
      fail           <= 1'b0;
      retry_cnt      <= 4'd0;
    end else begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
      if (start) begin
        state          <= PWRDN;
        cnt            <= PD_LD;
        pll_refclk_sel <= refclk_sel;
        pll_pd         <= 1'b1;
        pll_reset      <= 1'b1;
        busy           <= 1'b1;
        locked         <= 1'b0;
        fail           <= 1'b0;
        retry_cnt      <= 4'd0;
      end else begin
        case (state)
          PWRDN: if (cnt == '0) begin
            state  <= RESET;
            cnt    <= RST_LD;
            pll_pd <= 1'b0;
          end
          RESET: if (cnt == '0) begin
            state     <= WAIT_LOCK;
            cnt       <= TO_LD;
            pll_reset <= 1'b0;
          end
          WAIT_LOCK: begin
            // Lock beats a timeout landing on the same cycle.
            if (lock_ok) begin
              state  <= LOCKED;
              busy   <= 1'b0;
              locked <= 1'b1;
            end else if (cnt == '0) begin
              retry_cnt <= retry_inc;
              pll_reset <= 1'b1;
              if (retry_cnt < MAX_R) begin
                state <= RESET;
                cnt   <= RST_LD;
              end else begin
                state  <= FAILED;
                pll_pd <= 1'b1;
                busy   <= 1'b0;
                fail   <= 1'b1;
              end
            end
          end
          LOCKED: if (!lock_s) begin
            // Relock skips power-down: only the reset pulse is repeated.
            state     <= RESET;
            cnt       <= RST_LD;
            retry_cnt <= 4'd0;
            pll_reset <= 1'b1;
            busy      <= 1'b1;
            locked    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
